// File: rtl/game_pkg.sv
// Shared game types: event-controller state and common field widths.
// Also imported by the game-state FSM and the HUD renderer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    EXPLODE,
    RESPAWN,
    OVER
  } ev_state_t;

  localparam int LIVES_W   = 2;
  localparam int PENDING_W = 5;
  localparam int KILL_W    = 7;

endpackage

// File: rtl/enemy_popcount.sv
// Combinational population count of an enemy mask.
// Shared with the renderer HUD.
module enemy_popcount #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++)
      count = count + W'(mask[i]);
  end

endmodule

// File: rtl/game_event_ctrl.sv
// Per-frame event generator: kills, hit metering, death/respawn, lives.
// Bonus lives per kill count are enabled by GAME_EVENT_EXTRA_LIFE_EN.
module game_event_ctrl #(
  parameter int NUM_ENEMIES      = 8,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 3,
  parameter int EXPLODE_FRAMES   = 32,
  parameter int INVULN_FRAMES    = 64,
  parameter int EXTRA_LIFE_KILLS = 20
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   level,
  input  logic [NUM_ENEMIES-1:0] enemy_shot,
  input  logic                   player_struck,
  output logic                   hit,
  output logic                   explode,
  output logic [NUM_ENEMIES-1:0] enemy_alive,
  output logic [1:0]             lives,
  output logic                   invuln,
  output logic                   wave_clear,
  output logic                   game_over
);
  import game_pkg::*;

  localparam int TMAX =
    (EXPLODE_FRAMES > INVULN_FRAMES) ?
    EXPLODE_FRAMES : INVULN_FRAMES;
  localparam int TW  = $clog2(TMAX + 1);
  localparam int PCW = $clog2(NUM_ENEMIES + 1);
  localparam logic [TW-1:0] EXP_LD =
    TW'(EXPLODE_FRAMES - 1);
  localparam logic [TW-1:0] INV_LD =
    TW'(INVULN_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_RST =
    LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX =
    LIVES_W'(MAX_LIVES);
  localparam logic [NUM_ENEMIES-1:0] ALL = '1;

  ev_state_t state_q, state_d;
  logic [NUM_ENEMIES-1:0] alive_q, alive_d;
  logic [NUM_ENEMIES-1:0] newly, left;
  logic [PENDING_W-1:0] pend_q, pend_d, sat;
  logic [PENDING_W:0] sum;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [PCW-1:0] pc;
  logic hit_q, hit_d;
  logic exp_q, exp_d;
  logic inv_q, inv_d;
  logic wclr_q, wclr_d;
  logic over_q, over_d;
  logic active, death, bonus;
`ifdef GAME_EVENT_EXTRA_LIFE_EN
  logic [KILL_W-1:0] kills_q, kills_d;
`endif

  assign newly = enemy_shot & alive_q;
  assign left  = alive_q & ~enemy_shot;

  enemy_popcount #(
    .N(NUM_ENEMIES),
    .W(PCW)
  ) u_pc (
    .mask (newly),
    .count(pc)
  );

  assign sum = {1'b0, pend_q} + (PENDING_W+1)'(pc);
  assign sat = sum[PENDING_W] ? '1 : sum[PENDING_W-1:0];

  assign active = (state_q == PLAY)
               || (state_q == EXPLODE)
               || (state_q == RESPAWN);

  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    pend_d  = pend_q;
    lives_d = lives_q;
    tmr_d   = tmr_q;
    hit_d   = 1'b0;
    exp_d   = exp_q;
    inv_d   = inv_q;
    wclr_d  = 1'b0;
    over_d  = over_q;
    death   = 1'b0;
    bonus   = 1'b0;
`ifdef GAME_EVENT_EXTRA_LIFE_EN
    kills_d = kills_q;
`endif

    if (active) begin
      hit_d  = (sat != '0);
      pend_d = sat - PENDING_W'(hit_d);
      // an empty mask only lasts one frame before the wave reloads
      if (alive_q == '0) begin
        alive_d = ALL;
      end else begin
        alive_d = left;
        wclr_d  = (left == '0);
      end
    end

    unique case (state_q)
      IDLE: begin
        alive_d = ALL;
        lives_d = LIVES_RST;
        pend_d  = '0;
        if (level)
          state_d = PLAY;
      end
      PLAY: begin
        if (player_struck && !inv_q) begin
          death   = 1'b1;
          state_d = EXPLODE;
          exp_d   = 1'b1;
          tmr_d   = EXP_LD;
        end
      end
      EXPLODE: begin
        if (tmr_q == '0) begin
          exp_d = 1'b0;
          if (lives_q == '0) begin
            state_d = OVER;
            over_d  = 1'b1;
          end else begin
            state_d = RESPAWN;
            inv_d   = 1'b1;
            tmr_d   = INV_LD;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RESPAWN: begin
        if (tmr_q == '0) begin
          inv_d   = 1'b0;
          state_d = PLAY;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      OVER: begin
        hit_d  = (pend_q != '0);
        pend_d = pend_q - PENDING_W'(hit_d);
      end
      default: state_d = IDLE;
    endcase

`ifdef GAME_EVENT_EXTRA_LIFE_EN
    if (active && hit_d) begin
      if (kills_q == KILL_W'(EXTRA_LIFE_KILLS - 1)) begin
        kills_d = '0;
        bonus   = 1'b1;
      end else begin
        kills_d = kills_q + 1'b1;
      end
    end
`endif

    // a bonus landing on the death frame cancels the decrement
    if (bonus && !death) begin
      if (lives_q != LIVES_MAX)
        lives_d = lives_q + 1'b1;
    end else if (death && !bonus) begin
      if (lives_q != '0)
        lives_d = lives_q - 1'b1;
    end

    if (active && !level) begin
      state_d = IDLE;
      alive_d = ALL;
      pend_d  = '0;
      lives_d = LIVES_RST;
      tmr_d   = '0;
      hit_d   = 1'b0;
      exp_d   = 1'b0;
      inv_d   = 1'b0;
      wclr_d  = 1'b0;
`ifdef GAME_EVENT_EXTRA_LIFE_EN
      kills_d = '0;
`endif
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      alive_q <= ALL;
      pend_q  <= '0;
      lives_q <= LIVES_RST;
      tmr_q   <= '0;
      hit_q   <= 1'b0;
      exp_q   <= 1'b0;
      inv_q   <= 1'b0;
      wclr_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      pend_q  <= pend_d;
      lives_q <= lives_d;
      tmr_q   <= tmr_d;
      hit_q   <= hit_d;
      exp_q   <= exp_d;
      inv_q   <= inv_d;
      wclr_q  <= wclr_d;
      over_q  <= over_d;
    end
  end

`ifdef GAME_EVENT_EXTRA_LIFE_EN
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      kills_q <= '0;
    else
      kills_q <= kills_d;
  end
`endif

  assign hit         = hit_q;
  assign explode     = exp_q;
  assign enemy_alive = alive_q;
  assign lives       = lives_q;
  assign invuln      = inv_q;
  assign wave_clear  = wclr_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_game_event_ctrl.sv
// Directed bench for game_event_ctrl with a hit-pulse scoreboard.
// Bonus-life steps run only when GAME_EVENT_EXTRA_LIFE_EN is defined.
module tb_game_event_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       level;
  logic [7:0] enemy_shot;
  logic       player_struck;
  logic       hit;
  logic       explode;
  logic [7:0] enemy_alive;
  logic [1:0] lives;
  logic       invuln;
  logic       wave_clear;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  int hits_seen = 0;
  int sb[$];

  game_event_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .level        (level),
    .enemy_shot   (enemy_shot),
    .player_struck(player_struck),
    .hit          (hit),
    .explode      (explode),
    .enemy_alive  (enemy_alive),
    .lives        (lives),
    .invuln       (invuln),
    .wave_clear   (wave_clear),
    .game_over    (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++)
      sb.push_back(i);
  endtask

  // each hit pulse must match a kill queued by the stimulus
  always @(negedge frame_clk) begin
    if (!Reset && hit === 1'b1) begin
      hits_seen++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_hit: observed 1 expected 0");
      end
      if (sb.size() > 0)
        void'(sb.pop_front());
    end
  end

  task automatic wait_explode(output int n);
    n = 1;
    for (int k = 0; k < 100 && explode; k++) begin
      tick();
      if (explode) n++;
    end
  endtask

  task automatic wait_invuln(input int clr_at,
                             output int m);
    m = 1;
    for (int k = 0; k < 200 && invuln; k++) begin
      tick();
      if (invuln) m++;
      if (m == clr_at) player_struck = 1'b0;
    end
  endtask

  int n;
  int m;

  initial begin
    Reset = 1'b1;
    level = 1'b0;
    enemy_shot = '0;
    player_struck = 1'b0;
    #12;
    chk("rst_hit", hit, 0);
    chk("rst_explode", explode, 0);
    chk("rst_alive", enemy_alive, 8'hFF);
    chk("rst_lives", lives, 3);
    chk("rst_invuln", invuln, 0);
    chk("rst_wclr", wave_clear, 0);
    chk("rst_over", game_over, 0);
    Reset = 1'b0;

    level = 1'b1;
    tick();
    enemy_shot = 8'h01;
    push(1);
    tick();
    chk("k1_alive", enemy_alive, 8'hFE);
    chk("k1_hit", hit, 1);
    chk("k1_lives", lives, 3);
    enemy_shot = '0;
    tick();
    chk("k1_hit_end", hit, 0);

    enemy_shot = 8'h0F;
    push(3);
    tick();
    chk("k3_alive", enemy_alive, 8'hF0);
    chk("k3_hit_a", hit, 1);
    tick();
    chk("k3_hit_b", hit, 1);
    chk("k3_alive_rep", enemy_alive, 8'hF0);
    enemy_shot = '0;
    tick();
    chk("k3_hit_c", hit, 1);
    tick();
    chk("k3_hit_end", hit, 0);
    chk("k3_sb", sb.size(), 0);

    enemy_shot = 8'hF0;
    push(4);
    tick();
    chk("wc_alive0", enemy_alive, 8'h00);
    chk("wc_pulse", wave_clear, 1);
    enemy_shot = '0;
    tick();
    chk("wc_reload", enemy_alive, 8'hFF);
    chk("wc_pulse_end", wave_clear, 0);
    chk("wc_drain", hit, 1);
    tick();
    tick();
    tick();
    chk("wc_hit_end", hit, 0);
    chk("wave_hits", hits_seen, 8);
    chk("wave_sb", sb.size(), 0);

    player_struck = 1'b1;
    tick();
    chk("d1_explode", explode, 1);
    chk("d1_lives", lives, 2);
    player_struck = 1'b0;
    wait_explode(n);
    chk("d1_exp_frames", n, 32);
    chk("d1_invuln", invuln, 1);
    player_struck = 1'b1;
    wait_invuln(10, m);
    chk("d1_inv_frames", m, 64);
    chk("d1_lives_inv", lives, 2);
    chk("d1_no_explode", explode, 0);

    enemy_shot = 8'h01;
    player_struck = 1'b1;
    push(1);
    tick();
    chk("d2_hit", hit, 1);
    chk("d2_explode", explode, 1);
    chk("d2_lives", lives, 1);
    chk("d2_alive", enemy_alive, 8'hFE);
    enemy_shot = '0;
    player_struck = 1'b0;
    wait_explode(n);
    wait_invuln(0, m);

    player_struck = 1'b1;
    tick();
    chk("d3_lives", lives, 0);
    player_struck = 1'b0;
    wait_explode(n);
    chk("d3_exp_frames", n, 32);
    chk("d3_over", game_over, 1);
    chk("d3_invuln", invuln, 0);
    chk("d3_lives_end", lives, 0);
    level = 1'b0;
    tick();
    tick();
    level = 1'b1;
    enemy_shot = 8'hFF;
    tick();
    tick();
    enemy_shot = '0;
    chk("ov_sticky", game_over, 1);
    chk("ov_frozen", enemy_alive, 8'hFE);
    chk("ov_lives", lives, 0);
    chk("ov_sb", sb.size(), 0);

    Reset = 1'b1;
    #2;
    chk("rr_lives", lives, 3);
    chk("rr_over", game_over, 0);
    chk("rr_alive", enemy_alive, 8'hFF);
    Reset = 1'b0;

    tick();
    player_struck = 1'b1;
    tick();
    chk("lv_explode", explode, 1);
    chk("lv_lives", lives, 2);
    player_struck = 1'b0;
    level = 1'b0;
    tick();
    chk("lv_drop_exp", explode, 0);
    chk("lv_drop_lives", lives, 3);

`ifdef GAME_EVENT_EXTRA_LIFE_EN
    level = 1'b1;
    tick();
    player_struck = 1'b1;
    tick();
    player_struck = 1'b0;
    wait_explode(n);
    wait_invuln(0, m);
    chk("xl_start", lives, 2);
    for (int i = 0; i < 40; i++) begin
      enemy_shot = 8'h01 << (i % 8);
      push(1);
      tick();
      enemy_shot = '0;
      chk("xl_hit", hit, 1);
      if (i == 18) chk("xl_19", lives, 2);
      if (i == 19) chk("xl_20", lives, 3);
      if (i == 39) chk("xl_40", lives, 3);
      tick();
    end
    tick();
    chk("xl_sb", sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
